// File: rtl/mudi_pkg.sv
// mudi_pkg: shared definitions for the E-stage multiply/divide unit.
// - mudi_op_e    : operation encoding, identical to the decoder's mudiOp field.
// - mudi_state_e : IDLE/RUN states of the unit's sequencing FSM.
// - default busy latencies for mult/multu and div/divu.
package mudi_pkg;

  typedef enum logic [2:0] {
    MUDI_MULT  = 3'b000,
    MUDI_MULTU = 3'b001,
    MUDI_DIV   = 3'b010,
    MUDI_DIVU  = 3'b011,
    MUDI_MTHI  = 3'b100,
    MUDI_MTLO  = 3'b101,
    MUDI_RSV6  = 3'b110,  // reserved, behaves as a no-op
    MUDI_RSV7  = 3'b111   // reserved, behaves as a no-op
  } mudi_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mudi_state_e;

  localparam int unsigned MUDI_MULT_CYCLES = 5;
  localparam int unsigned MUDI_DIV_CYCLES  = 10;

  // True for the four ops that occupy the unit for several cycles.
  function automatic logic is_long_op(mudi_op_e op);
    return op inside {MUDI_MULT, MUDI_MULTU, MUDI_DIV, MUDI_DIVU};
  endfunction

endpackage

// File: rtl/mudi_if.sv
// mudi_if: pipeline-side bundle of the multiply/divide unit.
// master = E-stage pipeline (drives controls/operands, reads results),
// slave  = mudi_unit.
//   start   : decoder isStart for the instruction in E
//   op      : decoder mudiOp (see mudi_pkg::mudi_op_e)
//   src_a/b : forwarded rs/rt values
//   sel_hi  : decoder MUDI_sel, 1 = read HI, 0 = read LO
//   busy    : a mult/div is in flight
//   hi/lo   : architectural HI/LO registers
//   rd_data : sel_hi ? hi : lo (combinational)
interface mudi_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        sel_hi;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (
    output start, op, src_a, src_b, sel_hi,
    input  busy, hi, lo, rd_data
  );

  modport slave (
    input  start, op, src_a, src_b, sel_hi,
    output busy, hi, lo, rd_data
  );
endinterface

// File: rtl/mudi_arith.sv
// mudi_arith: purely combinational arithmetic core.
//   op       in  : latched operation
//   a, b     in  : latched operands (rs, rt)
//   result   out : {hi, lo} value to commit
//   div_zero out : div/divu with a zero divisor; HI/LO must not be written
module mudi_arith
  import mudi_pkg::*;
(
  input  mudi_op_e    op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s_safe;
  logic        [31:0] b_safe;
  logic               div_ovf;

  assign a_sx = {{32{a[31]}}, a};
  assign b_sx = {{32{b[31]}}, b};

  // A zero divisor is replaced by 1 so the dividers never see 0; the
  // quotient is discarded anyway because div_zero blocks the commit.
  assign b_safe   = (b == '0) ? 32'd1 : b;
  assign a_s      = a;
  assign b_s_safe = b_safe;

  // The only signed quotient that does not fit in 32 bits: pin it explicitly.
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would infer a latch.
    result   = '0;
    div_zero = 1'b0;
    case (op)
      MUDI_MULT:  result = a_sx * b_sx;
      MUDI_MULTU: result = {32'b0, a} * {32'b0, b};
      MUDI_DIV: begin
        div_zero = (b == '0);
        if (div_ovf) result = {32'h0000_0000, 32'h8000_0000};
        else         result = {32'(a_s % b_s_safe), 32'(a_s / b_s_safe)};
      end
      MUDI_DIVU: begin
        div_zero = (b == '0);
        result   = {a % b_safe, a / b_safe};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mudi_unit.sv
// mudi_unit: E-stage multiply/divide unit holding architectural HI/LO.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mudi_if.slave (start/op/src_a/src_b/sel_hi in; busy/hi/lo/rd_data out)
// A mult/div latches its op and operands at the start edge, then stays busy
// for MULT_CYCLES/DIV_CYCLES cycles and commits {hi,lo} at the edge where busy
// falls. mthi/mtlo write immediately. Any start while busy is ignored.
module mudi_unit
  import mudi_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MUDI_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MUDI_DIV_CYCLES
) (
  input  logic   clk,
  input  logic   rst_n,
  mudi_if.slave  bus
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  mudi_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  mudi_op_e           op_q,    op_d;
  logic [31:0]        a_q,     a_d;
  logic [31:0]        b_q,     b_d;
  logic [31:0]        hi_q,    hi_d;
  logic [31:0]        lo_q,    lo_d;

  mudi_op_e           op_in;
  logic               last_cycle;
  logic [63:0]        result;
  logic               div_zero;

  assign op_in      = mudi_op_e'(bus.op);
  assign last_cycle = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));

  mudi_arith u_arith (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .result   (result),
    .div_zero (div_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the latched op/operands are reset along with HI/LO; they are few
    // flops and a defined value keeps the arithmetic core free of X.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MUDI_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic: accept a long op only from IDLE, count down in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && is_long_op(op_in)) begin
          state_d = ST_RUN;
          op_d    = op_in;
          a_d     = bus.src_a;
          b_d     = bus.src_b;
          cnt_d   = (op_in inside {MUDI_MULT, MUDI_MULTU}) ? CNT_W'(MULT_CYCLES)
                                                           : CNT_W'(DIV_CYCLES);
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (last_cycle) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/register-update logic: HI/LO writes and the visible outputs.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (last_cycle) begin
      if (!div_zero) begin
        hi_d = result[63:32];
        lo_d = result[31:0];
      end
    end else if (state_q == ST_IDLE && bus.start) begin
      case (op_in)
        MUDI_MTHI: hi_d = bus.src_a;
        MUDI_MTLO: lo_d = bus.src_a;
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state_q == ST_RUN);
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.rd_data = bus.sel_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mudi_unit.sv
// tb_mudi_unit: directed bench for mudi_unit. A cycle-level reference model
// derives HI/LO/busy from the instruction semantics (64-bit arithmetic and a
// remaining-cycles count); a negedge process compares the DUT to it every
// cycle, and the directed sequence adds hand-computed literal checks.
module tb_mudi_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mudi_if bus ();

  mudi_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_calc(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, output bit valid);
    longint          sa, sb;
    longint unsigned ua, ub, qm, rm;
    logic [31:0]     q, r;
    valid = 1'b1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: begin
        ua = 64'(a); ub = 64'(b);
        return ua * ub;
      end
      3'd2: begin
        if (b == 32'd0) begin valid = 1'b0; return 64'd0; end
        ua = (sa < 0) ? 64'(-sa) : 64'(sa);
        ub = (sb < 0) ? 64'(-sb) : 64'(sb);
        qm = ua / ub;
        rm = ua % ub;
        q  = ((sa < 0) != (sb < 0)) ? 32'(-qm) : 32'(qm);
        r  = (sa < 0) ? 32'(-rm) : 32'(rm);
        return {r, q};
      end
      3'd3: begin
        if (b == 32'd0) begin valid = 1'b0; return 64'd0; end
        return {a % b, a / b};
      end
      default: begin valid = 1'b0; return 64'd0; end
    endcase
  endfunction

  int          m_left  = 0;
  logic [31:0] m_hi    = '0;
  logic [31:0] m_lo    = '0;
  logic [63:0] m_res   = '0;
  bit          m_valid = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0 && m_valid) begin
        m_hi = m_res[63:32];
        m_lo = m_res[31:0];
      end
    end else if (bus.start) begin
      case (bus.op)
        3'd0, 3'd1: begin m_left = MULT_N; m_res = model_calc(bus.op, bus.src_a, bus.src_b, m_valid); end
        3'd2, 3'd3: begin m_left = DIV_N;  m_res = model_calc(bus.op, bus.src_a, bus.src_b, m_valid); end
        3'd4: m_hi = bus.src_a;
        3'd5: m_lo = bus.src_a;
        default: ;
      endcase
    end
  end

  // Per-cycle comparison, away from the rising edge.
  always @(negedge clk) begin
    check("cyc_busy", 64'(bus.busy), 64'(m_left > 0));
    check("cyc_hi",   64'(bus.hi),   64'(m_hi));
    check("cyc_lo",   64'(bus.lo),   64'(m_lo));
    check("cyc_rd",   64'(bus.rd_data), 64'(bus.sel_hi ? m_hi : m_lo));
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge; issues one op and returns at the first falling
  // edge with busy low. Optionally injects a second start or a reset pulse
  // once inj_at busy cycles have been seen.
  task automatic run_op(input logic [2:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        input bit sel_i, input int inj_at, input logic [2:0] inj_op,
                        input logic [31:0] inj_a, input bit inj_rst, output int nbusy);
    bit done;
    done  = 1'b0;
    nbusy = 0;
    #1;
    bus.start  = 1'b1;
    bus.op     = op_i;
    bus.src_a  = a_i;
    bus.src_b  = b_i;
    bus.sel_hi = sel_i;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      else if (i > 0) done = 1'b1;
      if (!done) begin
        #1;
        bus.start = 1'b0;
        if (nbusy > 0 && nbusy == inj_at) begin
          if (inj_rst) begin
            rst_n = 1'b0;
            #1;
            check("rst_mid_busy", 64'(bus.busy), 64'd0);
            check("rst_mid_hi",   64'(bus.hi),   64'd0);
            check("rst_mid_lo",   64'(bus.lo),   64'd0);
            #2;
            rst_n = 1'b1;
          end else begin
            bus.start = 1'b1;
            bus.op    = inj_op;
            bus.src_a = inj_a;
          end
        end
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL busy_bound: busy still high after 64 cycles, got %0d busy cycles", nbusy);
    end
  endtask

  int n;

  initial begin
    bus.start  = 1'b0;
    bus.op     = 3'd0;
    bus.src_a  = '0;
    bus.src_b  = '0;
    bus.sel_hi = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_hi",   64'(bus.hi),   64'd0);
    check("reset_lo",   64'(bus.lo),   64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, -1, 3'd0, '0, 1'b0, n);
    check("mult_busy", 64'(n), 64'd5);
    check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(bus.lo), 64'hFFFF_FFFE);

    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, -1, 3'd0, '0, 1'b0, n);
    check("multu_busy", 64'(n), 64'd5);
    check("multu_hi", 64'(bus.hi), 64'h0000_0001);
    check("multu_lo", 64'(bus.lo), 64'hFFFF_FFFE);
    check("multu_rd_hi", 64'(bus.rd_data), 64'h0000_0001);

    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, -1, 3'd0, '0, 1'b0, n);
    check("div_busy", 64'(n), 64'd10);
    check("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);

    run_op(3'd4, 32'h0000_1234, 32'h0, 1'b1, -1, 3'd0, '0, 1'b0, n);
    check("mthi_busy", 64'(n), 64'd0);
    check("mthi_hi", 64'(bus.hi), 64'h0000_1234);
    run_op(3'd5, 32'h0000_5678, 32'h0, 1'b0, -1, 3'd0, '0, 1'b0, n);
    check("mtlo_lo", 64'(bus.lo), 64'h0000_5678);

    run_op(3'd3, 32'h0000_0007, 32'h0, 1'b0, -1, 3'd0, '0, 1'b0, n);
    check("divu0_busy", 64'(n), 64'd10);
    check("divu0_hi", 64'(bus.hi), 64'h0000_1234);
    check("divu0_lo", 64'(bus.lo), 64'h0000_5678);

    run_op(3'd0, 32'd3, 32'd4, 1'b0, 2, 3'd5, 32'h0000_DEAD, 1'b0, n);
    check("mult_inj_busy", 64'(n), 64'd5);
    check("mult_inj_hi", 64'(bus.hi), 64'h0);
    check("mult_inj_lo", 64'(bus.lo), 64'hC);
    check("mult_inj_rd", 64'(bus.rd_data), 64'hC);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, 3'd0, '0, 1'b0, n);
    check("div_ovf_lo", 64'(bus.lo), 64'h8000_0000);
    check("div_ovf_hi", 64'(bus.hi), 64'h0);

    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b1, -1, 3'd0, '0, 1'b0, n);
    check("div_negb_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    check("div_negb_hi", 64'(bus.hi), 64'h1);

    run_op(3'd3, 32'd100, 32'd7, 1'b0, -1, 3'd0, '0, 1'b0, n);
    check("divu_lo", 64'(bus.lo), 64'hE);
    check("divu_hi", 64'(bus.hi), 64'h2);

    run_op(3'd0, 32'hFFFF_8000, 32'd7, 1'b1, -1, 3'd0, '0, 1'b0, n);
    check("mult_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    check("mult_neg_lo", 64'(bus.lo), 64'hFFFC_8000);

    run_op(3'd6, 32'h1111_1111, 32'h2222_2222, 1'b0, -1, 3'd0, '0, 1'b0, n);
    check("rsv_busy", 64'(n), 64'd0);
    check("rsv_lo", 64'(bus.lo), 64'hFFFC_8000);

    run_op(3'd2, 32'd100, 32'd7, 1'b0, 3, 3'd0, '0, 1'b1, n);
    check("rst_run_busy_cycles", 64'(n), 64'd3);
    repeat (15) @(negedge clk);
    check("rst_after_busy", 64'(bus.busy), 64'd0);
    check("rst_after_hi", 64'(bus.hi), 64'd0);
    check("rst_after_lo", 64'(bus.lo), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mudi_unit.md
# mudi_unit

Multiply/divide unit in the E stage of the P6 pipeline. It consumes the decoder's `mudiOp`, `isStart` and `MUDI_sel` controls, together with the forwarded rs/rt operands. It holds the architectural HI/LO registers, models multi-cycle mult/div latency with a busy counter, and returns HI or LO for mfhi/mflo. The hazard unit uses `busy` to stall any mult/div/mfhi/mflo/mthi/mtlo sitting in D.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: decoder `isStart` for the instruction currently in E.
- `op` in 3: decoder `mudiOp`.
  - 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo.
  - 110 and 111 are reserved, treated as no-op.
- `src_a` in 32: forwarded rs value.
- `src_b` in 32: forwarded rt value.
- `sel_hi` in 1: decoder `MUDI_sel`; 1 selects HI, 0 selects LO.
- `busy` out 1: a mult/div is in flight.
- `hi` out 32: architectural HI register.
- `lo` out 32: architectural LO register.
- `rd_data` out 32: `sel_hi ? hi : lo`, combinational.

## Operation
- States: IDLE (`busy`=0) and RUN (`busy`=1); a down-counter `cnt` of width ceil(log2(DIV_CYCLES+1)).
- IDLE with `start`=1 and op in mult/multu/div/divu:
  - Latch `op`, `src_a`, `src_b`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- IDLE with `start`=1 and op mthi: `hi` ← `src_a` at this edge. Same for mtlo with `lo`. No busy.
- RUN: `cnt` decrements every edge. At the edge where `cnt`=1:
  - Commit the result to `hi`/`lo`.
  - Return to IDLE.
- Arithmetic is performed on the latched operands; results never depend on inputs after the start edge.
- mult: 64-bit signed product; `hi`=[63:32], `lo`=[31:0].
- multu: same, with unsigned operands.
- div: `lo`=quotient truncated toward zero; `hi`=remainder, taking the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- divu: unsigned quotient in `lo`, remainder in `hi`.
- Divisor 0 (div or divu): the full busy period still runs; `hi`/`lo` are left unchanged.
- `start`=1 while `busy`=1, any op: ignored, no state change. The hazard unit guarantees this never happens; the block still must not corrupt HI/LO if it does.
- `start`=1 with op 110/111: no-op.

## Timing
- Reset (`rst_n`=0, asynchronous): `hi`=0, `lo`=0, `busy`=0, `cnt`=0, state IDLE, all immediately.
  - Reset mid-RUN abandons the operation with no HI/LO commit.
- `start` sampled at edge E0. `busy`=1 from the cycle after E0 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- `hi`/`lo` take the new value in the same cycle that `busy` falls. That is N edges after E0.
- mthi/mtlo: new value visible in the cycle after E0; `busy` stays 0.
- `rd_data` is combinational on the current `hi`/`lo`. mfhi/mflo issued in the cycle `busy` drops reads the new result.
- The required hazard-unit stall term is `(start_E | busy)` AND D-instruction is MUDI-class. It is derived outside this block.
- Back-to-back: a new start is accepted in the first cycle with `busy`=0.

## Structure
- Shared package `mudi_pkg` holds:
  - Op encodings MUDI_MULT..MUDI_MTLO, matching the decoder's `mudiOp`.
  - Default cycle constants, 5 and 10.
- One combinational sub-module `mudi_arith`: latched op and operands in, 64-bit {hi,lo} result and a `div_zero` flag out.
- `mudi_unit` contains the FSM, counter and HI/LO registers.

## Test plan
- mult 0xFFFFFFFF × 0x00000002: `busy`=1 for 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE.
- multu with the same operands: `hi`=0x00000001, `lo`=0xFFFFFFFE after 5 busy cycles.
- div 0xFFFFFFF9 / 0x00000002: `busy`=1 for 10 cycles, then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- divu 7 / 0 after preload via mthi 0x1234 and mtlo 0x5678: 10 busy cycles, then `hi`=0x1234, `lo`=0x5678 unchanged.
- mult 3×4 with a mtlo 0xDEAD issued at busy cycle 2:
  - The mtlo is ignored.
  - `hi`=0, `lo`=0xC at busy fall.
  - `rd_data` with `sel_hi`=0 reads 0xC in that same cycle.
- div in flight with `rst_n` pulsed low at busy cycle 3: `busy`=0, `hi`=`lo`=0 immediately, and no commit after reset is released.
